// File: rtl/bp_pkg.sv
// bp_pkg: shared FSM state enum, update record type and scrub pass count for bp_update_ctrl
package bp_pkg;
  typedef enum logic {RUN, SCRUB} bp_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_upd_t;
  localparam int SCRUB_PASSES = 3;
endpackage

// File: rtl/bp_update_ctrl_if.sv
// bp_update_ctrl_if: EX resolve port (res_*), fetch redirect (flush_o, redirect_pc_o), predictor write port (upd_*), scrub control (flush_all_i, busy_o); slave = controller, master = EX/predictor side
interface bp_update_ctrl_if;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [31:0] res_pc_i;
  logic        res_taken_i;
  logic [31:0] res_target_i;
  logic        res_pred_taken_i;
  logic [31:0] res_pred_target_i;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic        upd_valid_o;
  logic        upd_ready_i;
  logic        upd_taken_o;
  logic [31:0] upd_addr_o;
  logic [31:0] upd_target_o;
  logic        flush_all_i;
  logic        busy_o;
  modport slave (
    input  res_valid_i, res_pc_i, res_taken_i, res_target_i, res_pred_taken_i, res_pred_target_i,
    input  upd_ready_i, flush_all_i,
    output res_ready_o, flush_o, redirect_pc_o, upd_valid_o, upd_taken_o, upd_addr_o, upd_target_o, busy_o
  );
  modport master (
    output res_valid_i, res_pc_i, res_taken_i, res_target_i, res_pred_taken_i, res_pred_target_i,
    output upd_ready_i, flush_all_i,
    input  res_ready_o, flush_o, redirect_pc_o, upd_valid_o, upd_taken_o, upd_addr_o, upd_target_o, busy_o
  );
endinterface

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: sync FIFO of bp_upd_t (clk, rst, push/din in, pop in, dout = head, full/empty out); pointers carry an extra wrap bit
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  bp_upd_t din,
  input  logic    pop,
  output bp_upd_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  bp_upd_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: BP write-port sequencer (clk, rst, bus.slave: res_* in, flush_o/redirect_pc_o/upd_*/busy_o out); predictor scrub FSM only when BP_SCRUB_EN is defined
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int NUM_INDEX_BIT = 3,
  parameter int DEPTH         = 4
) (
  input logic clk,
  input logic rst,
  bp_update_ctrl_if.slave bus
);
  bp_state_e state;
  bp_upd_t   head, rec;
  logic      full, empty, accept, pop, mis;
  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(accept), .din(rec), .pop(pop), .dout(head), .full(full), .empty(empty)
  );
  assign bus.res_ready_o = !full && state == RUN;
  assign accept = bus.res_valid_i && bus.res_ready_o;
  assign mis = bus.res_taken_i ? (!bus.res_pred_taken_i || bus.res_target_i != bus.res_pred_target_i)
                               : bus.res_pred_taken_i;
  assign rec = '{pc: bus.res_pc_i, taken: bus.res_taken_i, target: {bus.res_target_i[31:2], 2'b00}};
  assign pop = state == RUN && !empty && bus.upd_ready_i;
  assign bus.upd_taken_o  = state == RUN && !empty && head.taken;
  assign bus.upd_target_o = (state == RUN && !empty) ? head.target : '0;
`ifdef BP_SCRUB_EN
  logic [NUM_INDEX_BIT-1:0] idx;
  logic [1:0]               pass;
  assign bus.upd_valid_o = state == SCRUB || !empty;
  assign bus.upd_addr_o  = state == SCRUB ? 32'(idx) : (empty ? '0 : head.pc);
  assign bus.busy_o      = state == SCRUB;
`else
  logic unused_flush_all;
  assign unused_flush_all = bus.flush_all_i;
  assign bus.upd_valid_o  = !empty;
  assign bus.upd_addr_o   = empty ? '0 : head.pc;
  assign bus.busy_o       = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= RUN;
      bus.flush_o       <= 1'b0;
      bus.redirect_pc_o <= '0;
`ifdef BP_SCRUB_EN
      idx               <= '0;
      pass              <= '0;
`endif
    end else begin
      bus.flush_o <= accept && mis;
      if (accept && mis) bus.redirect_pc_o <= bus.res_taken_i ? bus.res_target_i : bus.res_pc_i + 32'd4;
`ifdef BP_SCRUB_EN
      if (state == RUN && bus.flush_all_i) begin
        state <= SCRUB;
        idx   <= '0;
        pass  <= '0;
      end else if (state == SCRUB && bus.upd_ready_i) begin
        pass <= (pass == 2'(SCRUB_PASSES - 1)) ? '0 : pass + 1'b1;
        if (pass == 2'(SCRUB_PASSES - 1)) begin
          idx <= idx + 1'b1;
          if (&idx) state <= RUN;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb_bp_update_ctrl: directed vector table plus corner sequences and a scoreboarded random run for bp_update_ctrl
module tb_bp_update_ctrl;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  bp_update_ctrl_if bus();
  bp_update_ctrl #(.NUM_INDEX_BIT(3), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        flush;
    logic [31:0] redirect;
    logic [31:0] upd_target;
  } vec_t;
  vec_t vecs [6];
  logic [31:0] q [$];
  logic [31:0] bp_pc [4];
  logic [31:0] bp_tg [4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_rec(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tg,
                         input logic pt, input logic [31:0] ptg);
    bus.res_valid_i       = v;
    bus.res_pc_i          = pc;
    bus.res_taken_i       = t;
    bus.res_target_i      = tg;
    bus.res_pred_taken_i  = pt;
    bus.res_pred_target_i = ptg;
  endtask
  initial begin
    vecs[0] = '{32'h100, 1, 32'h200, 0, 32'h0, 1, 32'h200, 32'h200};
    vecs[1] = '{32'h40, 1, 32'h80, 1, 32'h84, 1, 32'h80, 32'h80};
    vecs[2] = '{32'hFFFFFFFC, 0, 32'h1234, 1, 32'h1234, 1, 32'h0, 32'h1234};
    vecs[3] = '{32'h300, 1, 32'h400, 1, 32'h400, 0, 32'h0, 32'h400};
    vecs[4] = '{32'h500, 0, 32'h608, 0, 32'h0, 0, 32'h0, 32'h608};
    vecs[5] = '{32'h600, 1, 32'h203, 1, 32'h203, 0, 32'h0, 32'h200};
    set_rec(0, 0, 0, 0, 0, 0);
    bus.upd_ready_i = 1;
    bus.flush_all_i = 0;
    tick;
    tick;
    chk("rst_ready", bus.res_ready_o, 1);
    chk("rst_flush", bus.flush_o, 0);
    chk("rst_redirect", bus.redirect_pc_o, 0);
    chk("rst_upd_valid", bus.upd_valid_o, 0);
    chk("rst_upd_addr", bus.upd_addr_o, 0);
    chk("rst_upd_target", bus.upd_target_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      set_rec(1, vecs[i].pc, vecs[i].taken, vecs[i].target, vecs[i].pred_taken, vecs[i].pred_target);
      tick;
      bus.res_valid_i = 0;
      chk($sformatf("vec%0d_flush", i), bus.flush_o, vecs[i].flush);
      if (vecs[i].flush) chk($sformatf("vec%0d_redirect", i), bus.redirect_pc_o, vecs[i].redirect);
      chk($sformatf("vec%0d_upd_valid", i), bus.upd_valid_o, 1);
      chk($sformatf("vec%0d_upd_addr", i), bus.upd_addr_o, vecs[i].pc);
      chk($sformatf("vec%0d_upd_taken", i), bus.upd_taken_o, vecs[i].taken);
      chk($sformatf("vec%0d_upd_target", i), bus.upd_target_o, vecs[i].upd_target);
      tick;
      chk($sformatf("vec%0d_flush_drop", i), bus.flush_o, 0);
      chk($sformatf("vec%0d_drained", i), bus.upd_valid_o, 0);
    end
    set_rec(1, 32'h700, 1, 32'h900, 0, 0);
    tick;
    chk("b2b_flush_a", bus.flush_o, 1);
    chk("b2b_redirect_a", bus.redirect_pc_o, 32'h900);
    set_rec(1, 32'h800, 0, 32'h0, 1, 32'h40);
    tick;
    bus.res_valid_i = 0;
    chk("b2b_flush_b", bus.flush_o, 1);
    chk("b2b_redirect_b", bus.redirect_pc_o, 32'h804);
    tick;
    chk("b2b_flush_end", bus.flush_o, 0);
    tick;
    chk("b2b_drained", bus.upd_valid_o, 0);
    bp_pc = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
    bp_tg = '{32'h203, 32'h2000, 32'h3007, 32'h4000};
    bus.upd_ready_i = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_ready%0d", k), bus.res_ready_o, 1);
      set_rec(1, bp_pc[k], k[0], bp_tg[k], k[0], bp_tg[k]);
      tick;
    end
    chk("bp_full_ready", bus.res_ready_o, 0);
    chk("bp_head_valid", bus.upd_valid_o, 1);
    chk("bp_head_addr", bus.upd_addr_o, 32'h1000);
    set_rec(1, 32'hDEAD0000, 1, 32'h44, 1, 32'h44);
    tick;
    tick;
    bus.res_valid_i = 0;
    chk("bp_stall_addr", bus.upd_addr_o, 32'h1000);
    chk("bp_stall_target", bus.upd_target_o, 32'h200);
    chk("bp_stall_ready", bus.res_ready_o, 0);
    bus.upd_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_pop%0d_valid", k), bus.upd_valid_o, 1);
      chk($sformatf("bp_pop%0d_addr", k), bus.upd_addr_o, bp_pc[k]);
      chk($sformatf("bp_pop%0d_target", k), bus.upd_target_o, bp_tg[k] & 32'hFFFFFFFC);
      chk($sformatf("bp_pop%0d_taken", k), bus.upd_taken_o, k[0]);
      tick;
    end
    chk("bp_empty", bus.upd_valid_o, 0);
    chk("bp_ready_back", bus.res_ready_o, 1);
    bus.upd_ready_i = 0;
    set_rec(1, 32'h2000, 0, 0, 0, 0);
    tick;
    set_rec(1, 32'h2004, 0, 0, 0, 0);
    tick;
    bus.upd_ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      set_rec(1, 32'h2008 + 4 * k, 0, 0, 0, 0);
      chk($sformatf("pp%0d_ready", k), bus.res_ready_o, 1);
      chk($sformatf("pp%0d_addr", k), bus.upd_addr_o, 32'h2000 + 4 * k);
      tick;
    end
    bus.res_valid_i = 0;
    chk("pp_tail0", bus.upd_addr_o, 32'h200C);
    tick;
    chk("pp_tail1", bus.upd_addr_o, 32'h2010);
    tick;
    chk("pp_empty", bus.upd_valid_o, 0);
    q.delete();
    for (int c = 0; c < 100; c++) begin
      set_rec(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
              1'($urandom_range(0, 1)), $urandom);
      bus.upd_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rnd_ready", bus.res_ready_o, q.size() < 4);
      chk("rnd_valid", bus.upd_valid_o, q.size() != 0);
      if (q.size() != 0) chk("rnd_addr", bus.upd_addr_o, q[0]);
      if (q.size() != 0 && bus.upd_ready_i) void'(q.pop_front());
      if (bus.res_valid_i && q.size() + (bus.upd_ready_i && bus.upd_valid_o ? 1 : 0) < 5) begin
        if (bus.res_ready_o) q.push_back(bus.res_pc_i);
      end
      tick;
    end
    bus.res_valid_i = 0;
    bus.upd_ready_i = 1;
    for (int c = 0; c < 8 && q.size() != 0; c++) begin
      chk("rnd_drain_addr", bus.upd_addr_o, q[0]);
      void'(q.pop_front());
      tick;
    end
    chk("rnd_final_empty", bus.upd_valid_o, 0);
    bus.upd_ready_i = 0;
    set_rec(1, 32'h5000, 0, 0, 0, 0);
    tick;
    set_rec(1, 32'h5004, 0, 0, 0, 0);
    tick;
    set_rec(1, 32'h5008, 1, 32'h7000, 0, 0);
    tick;
    bus.res_valid_i = 0;
    chk("rstmid_pre_flush", bus.flush_o, 1);
    rst = 1;
    tick;
    rst = 0;
    chk("rstmid_upd_valid", bus.upd_valid_o, 0);
    chk("rstmid_ready", bus.res_ready_o, 1);
    chk("rstmid_flush", bus.flush_o, 0);
    chk("rstmid_redirect", bus.redirect_pc_o, 0);
    bus.upd_ready_i = 1;
    tick;
    chk("rstmid_stay_empty", bus.upd_valid_o, 0);
`ifdef BP_SCRUB_EN
    begin
      int n;
      n = 0;
      bus.upd_ready_i = 0;
      set_rec(1, 32'h3000, 1, 32'h3100, 1, 32'h3100);
      bus.flush_all_i = 1;
      tick;
      bus.res_valid_i = 0;
      bus.flush_all_i = 0;
      bus.upd_ready_i = 1;
      while (bus.busy_o && n < 100) begin
        bus.flush_all_i = n >= 5 && n < 8;
        chk("scrub_valid", bus.upd_valid_o, 1);
        chk("scrub_taken", bus.upd_taken_o, 0);
        chk("scrub_addr", bus.upd_addr_o, n / 3);
        chk("scrub_target", bus.upd_target_o, 0);
        chk("scrub_ready", bus.res_ready_o, 0);
        n++;
        tick;
      end
      bus.flush_all_i = 0;
      chk("scrub_writes", n, 24);
      chk("scrub_busy_end", bus.busy_o, 0);
      chk("scrub_queued_valid", bus.upd_valid_o, 1);
      chk("scrub_queued_addr", bus.upd_addr_o, 32'h3000);
      tick;
      chk("scrub_queued_drained", bus.upd_valid_o, 0);
    end
`else
    bus.upd_ready_i = 0;
    set_rec(1, 32'h3000, 1, 32'h3100, 1, 32'h3100);
    bus.flush_all_i = 1;
    tick;
    bus.res_valid_i = 0;
    bus.flush_all_i = 0;
    chk("noscrub_busy", bus.busy_o, 0);
    chk("noscrub_addr", bus.upd_addr_o, 32'h3000);
    chk("noscrub_ready", bus.res_ready_o, 1);
    bus.upd_ready_i = 1;
    tick;
    chk("noscrub_drained", bus.upd_valid_o, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
